// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link timing.
package uart_pkg;

    // Receiver FSM states (3-bit encoding, values 5..7 are illegal)
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BIT  = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Default link timing, shared with the transmitter
    localparam int DEFAULT_SYS_CLK_FREQUENCY = 50000000;
    localparam int DEFAULT_BAUD_RATE         = 9600;
    localparam int DEFAULT_CLKS_PER_BIT      = DEFAULT_SYS_CLK_FREQUENCY / DEFAULT_BAUD_RATE;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value selectable.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_reg;
    logic sync_reg;

    // Two back-to-back flops give metastability time before the value is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VALUE;
            sync_reg <= RESET_VALUE;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Samples each bit at its midpoint, pulses
// RX_Valid for a good frame, RX_Frame_Err for a low stop bit, and refuses new
// frames until the line has returned high after a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQUENCY = DEFAULT_SYS_CLK_FREQUENCY,
    parameter int BAUD_RATE         = DEFAULT_BAUD_RATE,
    parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX_In,
    output logic [7:0] RX_Out,
    output logic       RX_Valid,
    output logic       RX_Frame_Err,
    output logic       RX_Busy
);

    // Cycles from start-edge detection to the start-bit midpoint
    localparam int          HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam logic [31:0] HALF_CNT = 32'(HALF_BIT);
    localparam logic [31:0] LAST_CNT = 32'(CLKS_PER_BIT - 1);

    // Reject configurations where the midpoint arithmetic breaks down
    generate
        if (CLKS_PER_BIT < 4 || BAUD_RATE <= 0 || SYS_CLK_FREQUENCY < BAUD_RATE) begin : g_bad_cfg
            $error("uart_rx: invalid timing configuration");
        end
    endgenerate

    logic        rx_s;
    rx_state_t   state_reg,     state_next;
    logic [31:0] clk_count_reg, clk_count_next;
    logic [2:0]  bit_index_reg, bit_index_next;
    logic [7:0]  shift_reg,     shift_next;
    logic [7:0]  rx_out_reg,    rx_out_next;
    logic        valid_reg,     valid_next;
    logic        frame_err_reg, frame_err_next;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (RX_In),
        .dout  (rx_s)
    );

    // State, counters, datapath and output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            clk_count_reg <= '0;
            bit_index_reg <= '0;
            shift_reg     <= '0;
            rx_out_reg    <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_count_reg <= clk_count_next;
            bit_index_reg <= bit_index_next;
            shift_reg     <= shift_next;
            rx_out_reg    <= rx_out_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state, bit sampling and strobe generation
    always_comb begin
        state_next     = state_reg;
        clk_count_next = clk_count_reg;
        bit_index_next = bit_index_reg;
        shift_next     = shift_reg;
        rx_out_next    = rx_out_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                clk_count_next = '0;
                bit_index_next = '0;
                if (!rx_s) begin
                    state_next = START_BIT;
                end
            end

            START_BIT: begin
                if (clk_count_reg == HALF_CNT) begin
                    clk_count_next = '0;
                    // Still low at mid-start: real frame; otherwise a glitch
                    state_next     = rx_s ? IDLE : DATA_BIT;
                end else begin
                    clk_count_next = clk_count_reg + 32'd1;
                end
            end

            DATA_BIT: begin
                if (clk_count_reg == LAST_CNT) begin
                    clk_count_next            = '0;
                    shift_next[bit_index_reg] = rx_s;
                    if (bit_index_reg == 3'd7) begin
                        state_next = STOP_BIT;
                    end else begin
                        bit_index_next = bit_index_reg + 3'd1;
                    end
                end else begin
                    clk_count_next = clk_count_reg + 32'd1;
                end
            end

            STOP_BIT: begin
                if (clk_count_reg == LAST_CNT) begin
                    clk_count_next = '0;
                    // Leaving at the stop midpoint keeps half a bit of margin
                    // for a start bit that follows immediately
                    if (rx_s) begin
                        rx_out_next = shift_reg;
                        valid_next  = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_IDLE;
                    end
                end else begin
                    clk_count_next = clk_count_reg + 32'd1;
                end
            end

            WAIT_IDLE: begin
                clk_count_next = '0;
                bit_index_next = '0;
                // A held-low (break) line must not be read as a new start bit
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next     = IDLE;
                clk_count_next = '0;
                bit_index_next = '0;
            end
        endcase
    end

    assign RX_Out       = rx_out_reg;
    assign RX_Valid     = valid_reg;
    assign RX_Frame_Err = frame_err_reg;
    assign RX_Busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       RX_In;
    logic [7:0] RX_Out;
    logic       RX_Valid;
    logic       RX_Frame_Err;
    logic       RX_Busy;

    int total;
    int bad;

    int cyc;
    int valid_count;
    int err_count;
    int busy_seen;
    int long_pulse;
    int overlap;
    int valid_cyc;
    int start_cyc;
    logic       prev_valid;
    logic [7:0] byte_log [0:15];

    uart_rx #(
        .SYS_CLK_FREQUENCY (1600000),
        .BAUD_RATE         (100000),
        .CLKS_PER_BIT      (CPB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX_In        (RX_In),
        .RX_Out       (RX_Out),
        .RX_Valid     (RX_Valid),
        .RX_Frame_Err (RX_Frame_Err),
        .RX_Busy      (RX_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    initial begin
        valid_count = 0;
        err_count   = 0;
        busy_seen   = 0;
        long_pulse  = 0;
        overlap     = 0;
        valid_cyc   = 0;
        prev_valid  = 1'b0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (RX_Valid) begin
                byte_log[valid_count & 15] = RX_Out;
                valid_count = valid_count + 1;
                valid_cyc   = cyc;
                if (prev_valid) long_pulse = long_pulse + 1;
            end
            if (RX_Frame_Err) err_count = err_count + 1;
            if (RX_Busy) busy_seen = busy_seen + 1;
            if (RX_Valid && RX_Frame_Err) overlap = overlap + 1;
            prev_valid = RX_Valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Safety net: the run is fixed-length, this only fires if time runs away
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX_In = b;
        idle_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        $display("frame sent data=%02h stop=%0b", d, stop);
    endtask

    initial begin
        int v0;
        int e0;
        int b0;
        int lat;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        RX_In = 1'b1;

        // 1. reset and idle line
        idle_cycles(5);
        chk("rst_out",   32'(RX_Out), 32'h00);
        chk("rst_valid", 32'(RX_Valid), 0);
        chk("rst_err",   32'(RX_Frame_Err), 0);
        chk("rst_busy",  32'(RX_Busy), 0);
        rst_n = 1'b1;
        idle_cycles(100);
        chk("idle_valid", 32'(valid_count), 0);
        chk("idle_err",   32'(err_count), 0);
        chk("idle_busy",  32'(busy_seen), 0);
        chk("idle_out",   32'(RX_Out), 32'h00);
        $display("idle 100 cycles");

        // 2. frame 0xA5 with latency measurement
        v0 = valid_count;
        send_frame(8'hA5, 1'b1);
        lat = valid_cyc - start_cyc;
        chk("a5_pulses", 32'(valid_count - v0), 1);
        chk("a5_byte",   32'(byte_log[v0 & 15]), 32'hA5);
        chk("a5_out",    32'(RX_Out), 32'hA5);
        chk("a5_lat_in_window", 32'(lat >= 153 && lat <= 155), 1);
        chk("a5_busy_after", 32'(RX_Busy), 0);
        $display("latency measured=%0d cycles", lat);

        // 3. glitch shorter than half a bit
        v0 = valid_count;
        e0 = err_count;
        b0 = busy_seen;
        RX_In = 1'b0;
        idle_cycles(4);
        RX_In = 1'b1;
        idle_cycles(30);
        chk("glitch_valid",    32'(valid_count - v0), 0);
        chk("glitch_err",      32'(err_count - e0), 0);
        chk("glitch_out",      32'(RX_Out), 32'hA5);
        chk("glitch_busy",     32'(RX_Busy), 0);
        chk("glitch_detected", 32'(busy_seen > b0), 1);
        $display("glitch 4 cycles");

        // 4. back-to-back 0x00 then 0xFF
        v0 = valid_count;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_cycles(10);
        chk("b2b_pulses", 32'(valid_count - v0), 2);
        chk("b2b_first",  32'(byte_log[v0 & 15]), 32'h00);
        chk("b2b_second", 32'(byte_log[(v0 + 1) & 15]), 32'hFF);
        chk("b2b_out",    32'(RX_Out), 32'hFF);

        // 5. framing error, line held low, then recovery
        v0 = valid_count;
        e0 = err_count;
        send_frame(8'h3C, 1'b0);
        idle_cycles(40);
        chk("ferr_pulses", 32'(err_count - e0), 1);
        chk("ferr_valid",  32'(valid_count - v0), 0);
        chk("ferr_out",    32'(RX_Out), 32'hFF);
        chk("ferr_busy_low_line", 32'(RX_Busy), 1);
        RX_In = 1'b1;
        idle_cycles(20);
        chk("ferr_busy_released", 32'(RX_Busy), 0);
        $display("line released after break");
        v0 = valid_count;
        send_frame(8'h5A, 1'b1);
        chk("rec_pulses", 32'(valid_count - v0), 1);
        chk("rec_out",    32'(RX_Out), 32'h5A);
        chk("rec_err",    32'(err_count - e0), 1);

        // 6. reset in the middle of bit 4 of 0x81
        v0 = valid_count;
        e0 = err_count;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        RX_In = 1'b0;
        idle_cycles(8);
        rst_n = 1'b0;
        #2;
        chk("midrst_out",   32'(RX_Out), 32'h00);
        chk("midrst_valid", 32'(RX_Valid), 0);
        chk("midrst_err",   32'(RX_Frame_Err), 0);
        chk("midrst_busy",  32'(RX_Busy), 0);
        $display("reset asserted mid-frame");
        RX_In = 1'b1;
        idle_cycles(5);
        rst_n = 1'b1;
        idle_cycles(20);
        chk("postrst_valid", 32'(valid_count - v0), 0);
        chk("postrst_err",   32'(err_count - e0), 0);
        v0 = valid_count;
        send_frame(8'h42, 1'b1);
        chk("postrst_pulses", 32'(valid_count - v0), 1);
        chk("postrst_out",    32'(RX_Out), 32'h42);

        // Global pulse properties over the whole run
        idle_cycles(5);
        chk("pulse_width_one", 32'(long_pulse), 0);
        chk("valid_err_exclusive", 32'(overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
